spw_timecode_ctrl: RTL and testbench



---
 rtl/spw_timecode_ctrl_if.sv | 20 ++
 rtl/spw_timecode_ctrl.sv | 149 ++++++++++++++
 tb/tb_spw_timecode_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spw_timecode_ctrl_if.sv
// Avalon-MM slave bus bundle for the SpaceWire time-code controller,
// including the level interrupt returned to the CPU.
interface spw_timecode_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/spw_timecode_ctrl.sv
// SpaceWire time-code controller: captures and checks received time-codes,
// issues one-shot or periodic time-codes to the CODEC, raises a level irq.
module spw_timecode_ctrl #(
    parameter int PERIOD_W = 24,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    spw_timecode_ctrl_if.slave  bus,
    input  logic                link_running,
    input  logic                tick_out,
    input  logic [7:0]          time_out,
    output logic                tick_in,
    output logic [7:0]          time_in
);

    typedef enum logic [1:0] {IDLE, ARMED, STROBE} tx_state_t;

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic                 r_rx_valid, r_rx_overrun, r_seq_err;
    logic [7:0]           r_rx_time;
    logic [CNT_W-1:0]     r_rx_count;
    logic [3:0]           r_ctrl;
    logic [7:0]           r_tx_time;
    logic [PERIOD_W-1:0]  r_period;
    logic [PERIOD_W-1:0]  r_pcnt;
    logic [31:0]          r_readdata;
    logic                 r_irq;

    logic                 w_wr, w_wr_status, w_wr_ctrl, w_wr_tx, w_wr_period, w_wr_count;
    logic                 w_valid_nxt, w_ovr_nxt, w_seq_nxt, w_seq_hit;
    logic [3:0]           w_ctrl_nxt;
    logic                 w_irq_nxt;
    logic                 w_auto_on, w_auto_evt;
    logic                 w_tx_busy, w_strobe;
    logic [31:0]          w_rd;
    logic                 w_unused_wdata;

    assign w_wr        = bus.chipselect & ~bus.write_n;
    assign w_wr_status = w_wr && (bus.address == 3'd0);
    assign w_wr_ctrl   = w_wr && (bus.address == 3'd2);
    assign w_wr_tx     = w_wr && (bus.address == 3'd3);
    assign w_wr_period = w_wr && (bus.address == 3'd4);
    assign w_wr_count  = w_wr && (bus.address == 3'd5);
    assign w_unused_wdata = ^bus.writedata[31:8];

    assign w_seq_hit = (r_rx_count != '0) && (time_out[5:0] != (r_rx_time[5:0] + 6'd1));

    // W1C is applied first so that a same-cycle receive event re-sets the flag
    always_comb begin
        w_valid_nxt = r_rx_valid;
        w_ovr_nxt   = r_rx_overrun;
        w_seq_nxt   = r_seq_err;
        if (w_wr_status) begin
            w_valid_nxt = r_rx_valid   & ~bus.writedata[0];
            w_ovr_nxt   = r_rx_overrun & ~bus.writedata[1];
            w_seq_nxt   = r_seq_err    & ~bus.writedata[2];
        end
        if (tick_out) begin
            if (r_rx_valid) w_ovr_nxt = 1'b1;
            if (w_seq_hit)  w_seq_nxt = 1'b1;
            w_valid_nxt = 1'b1;
        end
    end

    assign w_ctrl_nxt = w_wr_ctrl ? bus.writedata[3:0] : r_ctrl;
    assign w_irq_nxt  = (w_ctrl_nxt[0] & w_valid_nxt) | (w_ctrl_nxt[1] & (w_ovr_nxt | w_seq_nxt));

    assign w_auto_on  = r_ctrl[2] && (r_period != '0);
    assign w_auto_evt = w_auto_on && (r_pcnt == PERIOD_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_tx_busy   = 1'b1;
        w_strobe    = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_busy = 1'b0;
                if (w_wr_tx || w_auto_evt) w_state_nxt = ARMED;
            end
            ARMED:  if (link_running) w_state_nxt = STROBE;
            STROBE: begin
                w_strobe    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rd = '0;
        case (bus.address)
            3'd0: w_rd[3:0]          = {w_tx_busy, r_seq_err, r_rx_overrun, r_rx_valid};
            3'd1: w_rd[7:0]          = r_rx_time;
            3'd2: w_rd[3:0]          = r_ctrl;
            3'd3: w_rd[7:0]          = r_tx_time;
            3'd4: w_rd[PERIOD_W-1:0] = r_period;
            3'd5: w_rd[CNT_W-1:0]    = r_rx_count;
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
            r_seq_err    <= 1'b0;
            r_rx_time    <= '0;
            r_rx_count   <= '0;
            r_ctrl       <= '0;
            r_tx_time    <= '0;
            r_period     <= '0;
            r_pcnt       <= '0;
            r_readdata   <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rx_valid   <= w_valid_nxt;
            r_rx_overrun <= w_ovr_nxt;
            r_seq_err    <= w_seq_nxt;
            r_ctrl       <= w_ctrl_nxt;
            r_readdata   <= w_rd;
            r_irq        <= w_irq_nxt;
            if (tick_out) r_rx_time <= time_out;
            if (w_wr_count)    r_rx_count <= tick_out ? CNT_W'(1) : '0;
            else if (tick_out) r_rx_count <= r_rx_count + CNT_W'(1);
            if (w_wr_period) r_period <= bus.writedata[PERIOD_W-1:0];
            // Counter tracks PERIOD while idle so enabling auto mode starts a full period
            if (w_wr_period)
                r_pcnt <= bus.writedata[PERIOD_W-1:0];
            else if (!w_auto_on || r_pcnt <= PERIOD_W'(1))
                r_pcnt <= r_period;
            else
                r_pcnt <= r_pcnt - PERIOD_W'(1);
            if (w_wr_tx)
                r_tx_time <= bus.writedata[7:0];
            else if (w_strobe && r_ctrl[3])
                r_tx_time[5:0] <= r_tx_time[5:0] + 6'd1;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq;
    assign tick_in      = (r_state == STROBE);
    assign time_in      = r_tx_time;

endmodule

// File: tb/tb_spw_timecode_ctrl.sv
// Directed plus randomized bench for spw_timecode_ctrl, checked against a
// behavioural model of the receive flags and the transmit sequence.
module tb_spw_timecode_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       link_running = 1'b0;
    logic       tick_out = 1'b0;
    logic [7:0] time_out = 8'h00;
    logic       tick_in;
    logic [7:0] time_in;

    spw_timecode_ctrl_if bus_if();

    spw_timecode_ctrl #(.PERIOD_W(24), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus_if),
        .link_running (link_running),
        .tick_out     (tick_out),
        .time_out     (time_out),
        .tick_in      (tick_in),
        .time_in      (time_in)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0]  m_rx_time;
    logic [15:0] m_count;
    logic        m_valid, m_ovr, m_seq;

    logic [31:0] d;
    logic [7:0]  v, base, hold_v;
    logic [2:0]  clr;
    int          p, seen, npulse;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] dat);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = dat;
        cyc();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] dat);
        bus_if.address = a;
        cyc();
        dat = bus_if.readdata;
    endtask

    task automatic model_reset();
        m_rx_time = 8'h00;
        m_count   = 16'h0000;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        m_seq     = 1'b0;
    endtask

    // Spec rules: a receive sets overrun if a code was already pending, checks
    // mod-64 continuity against the previous code, and wins over a W1C.
    task automatic model_step(input bit t, input logic [7:0] val, input logic [2:0] c);
        bit old_valid;
        int expect_lo;
        old_valid = m_valid;
        m_valid = m_valid & ~c[0];
        m_ovr   = m_ovr   & ~c[1];
        m_seq   = m_seq   & ~c[2];
        if (t) begin
            expect_lo = (int'(m_rx_time[5:0]) + 1) % 64;
            if (old_valid) m_ovr = 1'b1;
            if (m_count != 0 && int'(val[5:0]) != expect_lo) m_seq = 1'b1;
            m_rx_time = val;
            m_count   = m_count + 16'd1;
            m_valid   = 1'b1;
        end
    endtask

    task automatic rx_tick(input logic [7:0] val, input logic [2:0] c);
        tick_out = 1'b1;
        time_out = val;
        if (c != 3'b000) begin
            bus_if.address    = 3'd0;
            bus_if.chipselect = 1'b1;
            bus_if.write_n    = 1'b0;
            bus_if.writedata  = {29'd0, c};
        end
        cyc();
        tick_out          = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        model_step(1'b1, val, c);
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] r;
        rd(3'd0, r);
        check($sformatf("%s_status", tag), r, {28'd0, 1'b0, m_seq, m_ovr, m_valid});
        rd(3'd1, r);
        check($sformatf("%s_rx_time", tag), r, {24'd0, m_rx_time});
        rd(3'd5, r);
        check($sformatf("%s_rx_count", tag), r, {16'd0, m_count});
    endtask

    task automatic monitor_auto(input int ncyc, input logic [7:0] b, input int per, input string tag);
        int          times[$];
        logic [7:0]  vals[$];
        logic [7:0]  ev;
        for (int c = 0; c < ncyc; c++) begin
            cyc();
            if (tick_in === 1'b1) begin
                times.push_back(c);
                vals.push_back(time_in);
            end
        end
        check($sformatf("%s_pulses_ge4", tag), 32'(times.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < times.size(); k++) begin
            ev = {b[7:6], 6'((int'(b[5:0]) + k) % 64)};
            check($sformatf("%s_val%0d", tag, k), {24'd0, vals[k]}, {24'd0, ev});
            if (k > 0)
                check($sformatf("%s_gap%0d", tag, k), 32'(times[k] - times[k-1]), 32'(per));
        end
    endtask

    initial begin
        bus_if.address    = 3'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        model_reset();

        // Reset state
        repeat (3) cyc();
        check("rst_readdata", bus_if.readdata, 32'd0);
        check("rst_irq", {31'd0, bus_if.irq}, 32'd0);
        check("rst_tick_in", {31'd0, tick_in}, 32'd0);
        check("rst_time_in", {24'd0, time_in}, 32'd0);
        reset_n = 1'b1;
        cyc();
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check($sformatf("rst_reg%0d", a), d, 32'd0);
        end

        // Directed RX sequence 05, 06, 08
        rx_tick(8'h05, 3'b000);
        check_rx("rx05");
        rx_tick(8'h06, 3'b000);
        check_rx("rx06");
        rd(3'd0, d);
        check("rx06_seq_clear", {31'd0, d[2]}, 32'd0);
        rx_tick(8'h08, 3'b000);
        check_rx("rx08");
        rd(3'd0, d);
        check("rx08_seq_set", {31'd0, d[2]}, 32'd1);
        rd(3'd1, d);
        check("rx08_time", d, 32'h08);
        rd(3'd5, d);
        check("rx08_count", d, 32'd3);
        wr(3'd0, 32'h7);
        model_step(1'b0, 8'h00, 3'b111);
        rd(3'd0, d);
        check("w1c_all", d, 32'd0);

        // Randomized receive stream with occasional W1C collisions
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            if ($urandom_range(0, 1) == 1) v[5:0] = m_rx_time[5:0] + 6'd1;
            clr = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            rx_tick(v, clr);
            check_rx($sformatf("rand%0d", i));
        end

        // Overrun and interrupt
        wr(3'd0, 32'h7);
        model_step(1'b0, 8'h00, 3'b111);
        wr(3'd2, 32'h3);
        check("irq_idle", {31'd0, bus_if.irq}, 32'd0);
        v = m_rx_time + 8'd1;
        rx_tick(v, 3'b000);
        check("irq_after_tick", {31'd0, bus_if.irq}, 32'd1);
        rx_tick(v + 8'd1, 3'b000);
        rd(3'd0, d);
        check("ovr_set", {31'd0, d[1]}, 32'd1);
        rx_tick(v + 8'd2, 3'b001);
        rd(3'd0, d);
        check("w1c_collide_valid", {31'd0, d[0]}, 32'd1);
        check("w1c_collide_model", d, {28'd0, 1'b0, m_seq, m_ovr, m_valid});
        wr(3'd0, 32'h7);
        model_step(1'b0, 8'h00, 3'b111);
        check("irq_cleared", {31'd0, bus_if.irq}, 32'd0);
        wr(3'd2, 32'h0);

        // One-shot transmit held off by the link, then released
        link_running = 1'b0;
        wr(3'd3, 32'h3F);
        rd(3'd0, d);
        check("oneshot_busy", {31'd0, d[3]}, 32'd1);
        seen = 0;
        repeat (5) begin
            cyc();
            if (tick_in === 1'b1) seen++;
        end
        check("oneshot_no_tick_link_down", 32'(seen), 32'd0);
        link_running = 1'b1;
        npulse = 0;
        hold_v = 8'h00;
        repeat (6) begin
            cyc();
            if (tick_in === 1'b1) begin
                npulse++;
                hold_v = time_in;
            end
        end
        check("oneshot_pulses", 32'(npulse), 32'd1);
        check("oneshot_time_in", {24'd0, hold_v}, 32'h3F);
        rd(3'd0, d);
        check("oneshot_idle", {31'd0, d[3]}, 32'd0);

        // Random value rewritten while armed: one strobe carrying the last value
        link_running = 1'b0;
        v = 8'($urandom);
        base = 8'($urandom);
        wr(3'd3, {24'd0, v});
        wr(3'd3, {24'd0, base});
        link_running = 1'b1;
        npulse = 0;
        repeat (8) begin
            cyc();
            if (tick_in === 1'b1) begin
                npulse++;
                hold_v = time_in;
            end
        end
        check("rewrite_pulses", 32'(npulse), 32'd1);
        check("rewrite_time_in", {24'd0, hold_v}, {24'd0, base});

        // Auto transmit with 6-bit wrap
        wr(3'd4, 32'd10);
        wr(3'd3, 32'hBE);
        repeat (6) cyc();
        check("auto_pre_value", {24'd0, time_in}, 32'hBE);
        wr(3'd2, 32'hC);
        monitor_auto(55, 8'hBE, 10, "auto10");
        wr(3'd2, 32'h0);
        repeat (6) cyc();

        p = $urandom_range(3, 12);
        base = 8'($urandom);
        wr(3'd4, 32'(p));
        wr(3'd3, {24'd0, base});
        repeat (6) cyc();
        wr(3'd2, 32'hC);
        monitor_auto(5 * p + 12, base, p, "autorand");
        wr(3'd2, 32'h0);
        repeat (6) cyc();

        // Unmapped addresses and RX_COUNT clear
        rd(3'd6, d);
        check("addr6", d, 32'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, d);
        check("addr7", d, 32'd0);
        wr(3'd5, 32'h1234);
        rd(3'd5, d);
        check("rx_count_clear", d, 32'd0);

        // Reset in the middle of a strobe
        wr(3'd2, 32'h3);
        wr(3'd4, 32'h123);
        link_running = 1'b0;
        wr(3'd3, 32'h55);
        link_running = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            cyc();
            if (tick_in === 1'b1) seen = 1;
        end
        check("strobe_reached", 32'(seen), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_tick_in", {31'd0, tick_in}, 32'd0);
        check("rst_mid_time_in", {24'd0, time_in}, 32'd0);
        repeat (2) cyc();
        reset_n = 1'b1;
        model_reset();
        npulse = 0;
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check($sformatf("post_rst_reg%0d", a), d, 32'd0);
            if (tick_in === 1'b1) npulse++;
        end
        check("post_rst_irq", {31'd0, bus_if.irq}, 32'd0);
        check("post_rst_no_pending", 32'(npulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
